ixc_assign_arb: RTL and testbench



---
 rtl/ixc_assign_arb.sv | 127 ++++++++++++
 tb/tb_ixc_assign_arb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ixc_assign_arb.sv
// rtl/ixc_assign_arb.sv - round-robin arbiter sharing one registered assign channel among NREQ burst requesters
// Grants are sticky for a burst; a grant is force-released after MAX_BURST beats.

module ixc_assign_arb #(
   parameter int WIDTH     = 296,
   parameter int NREQ      = 4,
   parameter int SW        = 2,
   parameter int MAX_BURST = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_last,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [SW-1:0]         out_src,
   output logic                  out_last,
   output logic                  burst_trunc
);

   typedef enum logic {IDLE, LOCK} state_t;

   localparam logic [7:0]    MAXB    = 8'(MAX_BURST);
   localparam logic [SW-1:0] PTR_RST = SW'(NREQ - 1);

   state_t           state_q;
   logic [SW-1:0]    ptr_q;
   logic [SW-1:0]    owner_q;
   logic [7:0]       beat_cnt_q;
   logic [7:0]       beat_cnt_d;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [SW-1:0]    out_src_q;
   logic             out_last_q;
   logic             burst_trunc_q;

   logic             win_found;
   logic [SW-1:0]    win_idx;
   logic [SW-1:0]    sel;
   logic             grant_ok;
   logic             slot_free;
   logic             accept;
   logic             sel_last;
   logic [WIDTH-1:0] sel_data;
   logic             forced;
   logic             treat_last;

   // Rotating priority: search starts just after the last requester to finish a grant.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = SW'(idx);
         end
      end
   end

   assign sel       = (state_q == LOCK) ? owner_q : win_idx;
   assign grant_ok  = (state_q == LOCK) || win_found;
   assign slot_free = !out_valid_q || out_ready;

   always_comb begin
      req_ready = '0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (SW'(i) == sel) begin
            req_ready[i] = !rst && grant_ok && slot_free;
            sel_last     = req_last[i];
            sel_data     = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign accept     = |(req_ready & req_valid);
   assign beat_cnt_d = ((state_q == LOCK) ? beat_cnt_q : 8'd0) + 8'd1;
   assign forced     = (beat_cnt_d == MAXB);
   assign treat_last = sel_last || forced;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= PTR_RST;
         owner_q       <= '0;
         beat_cnt_q    <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_src_q     <= '0;
         out_last_q    <= 1'b0;
         burst_trunc_q <= 1'b0;
      end else begin
         burst_trunc_q <= accept && forced && !sel_last;
         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_src_q   <= sel;
            out_last_q  <= treat_last;
            if (treat_last) begin
               state_q    <= IDLE;
               ptr_q      <= sel;
               beat_cnt_q <= '0;
            end else begin
               state_q    <= LOCK;
               owner_q    <= sel;
               beat_cnt_q <= beat_cnt_d;
            end
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_src     = out_src_q;
   assign out_last    = out_last_q;
   assign burst_trunc = burst_trunc_q;

endmodule

// File: tb/tb_ixc_assign_arb.sv
// tb/tb_ixc_assign_arb.sv - directed vector table plus randomized reference-model check for ixc_assign_arb

module tb_ixc_assign_arb;
   localparam int WIDTH = 296;
   localparam int NREQ  = 4;
   localparam int SW    = 2;
   localparam int MAXB  = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid, req_last, req_ready;
   logic [NREQ*WIDTH-1:0] req_data;
   logic                  out_valid, out_ready, out_last, burst_trunc;
   logic [WIDTH-1:0]      out_data;
   logic [SW-1:0]         out_src;

   int n_cmp = 0;
   int n_bad = 0;

   ixc_assign_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .SW(SW), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_src(out_src), .out_last(out_last), .burst_trunc(burst_trunc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] vld;
      logic [3:0] lst;
      logic       ordy;
      logic [3:0] rdy;
      logic       ov;
      logic [1:0] src;
      logic       last;
      logic       trunc;
   } vec_t;

   vec_t tq[$];

   task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] data_of(input int i);
      logic [7:0] b;
      b = 8'hA3 + 8'(i);
      return {37{b}};
   endfunction

   // Reference model: grant bookkeeping in plain integers.
   bit               m_lock, m_ov, m_last, m_tr;
   int               m_ptr, m_owner, m_cnt, m_src;
   logic [WIDTH-1:0] m_data;

   task automatic m_reset();
      m_lock = 0; m_ov = 0; m_last = 0; m_tr = 0;
      m_ptr = NREQ - 1; m_owner = 0; m_cnt = 0; m_src = 0; m_data = '0;
   endtask

   function automatic logic [3:0] m_ready();
      logic [3:0] r;
      bit slot;
      r = '0;
      slot = !m_ov || out_ready;
      if (rst || !slot) return r;
      if (m_lock) begin
         r[m_owner] = 1'b1;
         return r;
      end
      for (int k = 1; k <= NREQ; k++) begin
         if (req_valid[(m_ptr + k) % NREQ]) begin
            r[(m_ptr + k) % NREQ] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   task automatic m_step();
      logic [3:0] r;
      int acc, beats;
      bit lastb;
      r = m_ready() & req_valid;
      acc = -1;
      for (int i = 0; i < NREQ; i++) if (r[i]) acc = i;
      if (rst) begin
         m_reset();
         return;
      end
      m_tr = 0;
      if (acc >= 0) begin
         beats  = (m_lock ? m_cnt : 0) + 1;
         lastb  = req_last[acc] || (beats == MAXB);
         m_tr   = lastb && !req_last[acc];
         m_ov   = 1; m_src = acc; m_last = lastb;
         m_data = req_data[acc*WIDTH +: WIDTH];
         if (lastb) begin
            m_lock = 0; m_ptr = acc; m_cnt = 0;
         end else begin
            m_lock = 1; m_owner = acc; m_cnt = beats;
         end
      end else if (out_ready) begin
         m_ov = 0;
      end
   endtask

   task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic o,
                      input logic [3:0] rd, input logic ov, input logic [1:0] s,
                      input logic la, input logic tr);
      vec_t e;
      e = '{r, v, l, o, rd, ov, s, la, tr};
      tq.push_back(e);
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = data_of(i);

      // rst vld lst ordy | rdy ov src last trunc
      add(1, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0);
      add(0, 4'h4, 4'h4, 1, 4'h4, 1, 2, 1, 0);   // single beat from requester 2
      add(1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0);   // reset drops pending beat
      add(0, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 0);   // round robin 0,1,2,3,0
      add(0, 4'hF, 4'hF, 1, 4'h2, 1, 1, 1, 0);
      add(0, 4'hF, 4'hF, 1, 4'h4, 1, 2, 1, 0);
      add(0, 4'hF, 4'hF, 1, 4'h8, 1, 3, 1, 0);
      add(0, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 0);
      add(0, 4'h3, 4'h0, 1, 4'h2, 1, 1, 0, 0);   // 3-beat burst from 1, 0 blocked
      add(0, 4'h3, 4'h0, 1, 4'h2, 1, 1, 0, 0);
      add(0, 4'h3, 4'h2, 1, 4'h2, 1, 1, 1, 0);
      add(0, 4'h1, 4'h1, 1, 4'h1, 1, 0, 1, 0);
      add(0, 4'h8, 4'h0, 1, 4'h8, 1, 3, 0, 0);   // requester 3 streams, forced at beat 4
      add(0, 4'h9, 4'h0, 1, 4'h8, 1, 3, 0, 0);
      add(0, 4'h1, 4'h0, 1, 4'h8, 0, 3, 0, 0);   // owner gap keeps lock
      add(0, 4'h9, 4'h0, 1, 4'h8, 1, 3, 0, 0);
      add(0, 4'h9, 4'h0, 1, 4'h8, 1, 3, 1, 1);
      add(0, 4'h9, 4'h1, 1, 4'h1, 1, 0, 1, 0);   // requester 0 wins re-arbitration
      add(0, 4'h8, 4'h0, 1, 4'h8, 1, 3, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 4'h9, 4'h8, 0, 4'h0, 1, 3, 0, 0);   // backpressure
      add(0, 4'h9, 4'h8, 1, 4'h8, 1, 3, 1, 0);
      add(0, 4'h2, 4'h0, 1, 4'h2, 1, 1, 0, 0);   // reset on beat 2
      add(0, 4'h2, 4'h0, 1, 4'h2, 1, 1, 0, 0);
      add(1, 4'hF, 4'h0, 1, 4'h0, 0, 0, 0, 0);
      add(0, 4'hF, 4'h1, 1, 4'h1, 1, 0, 1, 0);

      for (int n = 0; n < tq.size(); n++) begin
         @(negedge clk);
         rst = tq[n].rst; req_valid = tq[n].vld; req_last = tq[n].lst; out_ready = tq[n].ordy;
         #1;
         chk($sformatf("vec%0d req_ready", n), WIDTH'(req_ready), WIDTH'(tq[n].rdy));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d out_valid", n), WIDTH'(out_valid), WIDTH'(tq[n].ov));
         chk($sformatf("vec%0d out_src", n), WIDTH'(out_src), WIDTH'(tq[n].src));
         chk($sformatf("vec%0d out_last", n), WIDTH'(out_last), WIDTH'(tq[n].last));
         chk($sformatf("vec%0d burst_trunc", n), WIDTH'(burst_trunc), WIDTH'(tq[n].trunc));
         if (tq[n].ov) chk($sformatf("vec%0d out_data", n), out_data, data_of(int'(tq[n].src)));
         else if (tq[n].rst) chk($sformatf("vec%0d out_data_rst", n), out_data, '0);
      end

      @(negedge clk);
      rst = 1'b1; req_valid = '0; out_ready = 1'b1;
      m_reset();
      @(posedge clk);
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 149) == 0);
         req_valid = 4'($urandom());
         for (int i = 0; i < NREQ; i++) req_last[i] = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         for (int w = 0; w < NREQ*WIDTH/32; w++) req_data[w*32 +: 32] = $urandom();
         #1;
         chk($sformatf("rnd%0d req_ready", n), WIDTH'(req_ready), WIDTH'(m_ready()));
         m_step();
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d out_valid", n), WIDTH'(out_valid), WIDTH'(m_ov));
         chk($sformatf("rnd%0d out_src", n), WIDTH'(out_src), WIDTH'(m_src));
         chk($sformatf("rnd%0d out_last", n), WIDTH'(out_last), WIDTH'(m_last));
         chk($sformatf("rnd%0d burst_trunc", n), WIDTH'(burst_trunc), WIDTH'(m_tr));
         chk($sformatf("rnd%0d out_data", n), out_data, m_data);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
